sddr_init_seq: RTL

- Power-up initialization sequencer for the DDR3 controller.
- Drives the PHY's controller-side command, ODT, write-level and DQS-strobe inputs and the DDR3 memory reset through the JEDEC bring-up: reset hold, CKE wait, tXPR, MR2/MR3/MR1/MR0, ZQCL, and optionally write leveling.
- Asserts init_done_o when the command path can be handed to the main scheduler.

---
 rtl/sddr_init_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sddr_init_seq.sv
// DDR3 power-up initialisation sequencer: RESET# hold, CKE wait, tXPR, MR2/3/1/0, ZQCL and DONE.
// Define SDDR_WRITE_LEVEL_EN to insert write-leveling (WL_ENTER/WL_RUN/WL_EXIT) between ZQCL and DONE.
module sddr_init_seq #(
  parameter int BANK_BITS      = 3,
  parameter int ADDR_BITS      = 14,
  parameter int RESET_CYCLES   = 60620,
  parameter int CKE_CYCLES     = 151550,
  parameter int TXPR_CYCLES    = 82,
  parameter int TMRD_CYCLES    = 4,
  parameter int TMOD_CYCLES    = 12,
  parameter int TZQINIT_CYCLES = 512,
  parameter logic [ADDR_BITS-1:0] MR0_VAL = '0,
  parameter logic [ADDR_BITS-1:0] MR1_VAL = '0,
  parameter logic [ADDR_BITS-1:0] MR2_VAL = '0,
  parameter logic [ADDR_BITS-1:0] MR3_VAL = '0,
  parameter int WL_PULSES      = 32,
  parameter int WL_GAP         = 16
) (
  input  logic                 in_ddr_clock_i,
  input  logic                 in_ctl_reset_n_i,
  input  logic                 restart_i,
  output logic                 ddr_reset_n_o,
  output logic                 ctl_cke_o,
  output logic                 ctl_cs_n_o,
  output logic                 ctl_ras_n_o,
  output logic                 ctl_cas_n_o,
  output logic                 ctl_we_n_o,
  output logic                 ctl_odt_o,
  output logic [ADDR_BITS-1:0] ctl_addr_o,
  output logic [BANK_BITS-1:0] ctl_ba_o,
  output logic                 ctl_write_level_o,
  output logic                 ctl_out_dqs_o,
  output logic                 init_done_o,
  output logic [3:0]           state_o
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One width covers every wait and the write-level pulse count.
  localparam int MAX_WAIT = imax(imax(imax(RESET_CYCLES, CKE_CYCLES), imax(TXPR_CYCLES, TMRD_CYCLES)),
                                 imax(imax(TMOD_CYCLES, TZQINIT_CYCLES), imax(WL_GAP, WL_PULSES)));
  localparam int CW = $clog2(MAX_WAIT) + 1;

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_ZQCL  = 4'b0110;

  typedef enum logic [3:0] {
    RESET_HOLD = 4'd0, CKE_WAIT = 4'd1, TXPR = 4'd2, MRS2 = 4'd3, MRS3 = 4'd4,
    MRS1 = 4'd5, MRS0 = 4'd6, ZQCL = 4'd7, DONE = 4'd8
`ifdef SDDR_WRITE_LEVEL_EN
    , WL_ENTER = 4'd9, WL_RUN = 4'd10, WL_EXIT = 4'd11
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  armed_q;
  logic                  entering, cnt_zero;
  logic                  reset_n_d, cke_d, done_d;
  logic [3:0]            cmd_q, cmd_d;
  logic [ADDR_BITS-1:0]  addr_d;
  logic [BANK_BITS-1:0]  ba_d;

  function automatic int wait_len(input state_t s);
    case (s)
      RESET_HOLD: return RESET_CYCLES;
      CKE_WAIT:   return CKE_CYCLES;
      TXPR:       return TXPR_CYCLES;
      MRS2, MRS3, MRS1: return TMRD_CYCLES;
      MRS0:       return TMOD_CYCLES;
      ZQCL:       return TZQINIT_CYCLES;
`ifdef SDDR_WRITE_LEVEL_EN
      WL_ENTER, WL_EXIT: return TMOD_CYCLES;
      WL_RUN:     return WL_GAP;
`endif
      default:    return 1;
    endcase
  endfunction

  assign cnt_zero = (cnt_q == '0);

`ifdef SDDR_WRITE_LEVEL_EN
  localparam int PW = $clog2(WL_PULSES + 1);
  logic [PW-1:0] pulse_q, pulse_d;
  logic          wl_d, dqs_d, wl_q, dqs_q;
`endif

  // restart_i is a level request sampled every edge; only DONE acts on it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_HOLD: if (armed_q && cnt_zero) state_d = CKE_WAIT;
      CKE_WAIT:   if (cnt_zero) state_d = TXPR;
      TXPR:       if (cnt_zero) state_d = MRS2;
      MRS2:       if (cnt_zero) state_d = MRS3;
      MRS3:       if (cnt_zero) state_d = MRS1;
      MRS1:       if (cnt_zero) state_d = MRS0;
      MRS0:       if (cnt_zero) state_d = ZQCL;
`ifdef SDDR_WRITE_LEVEL_EN
      ZQCL:       if (cnt_zero) state_d = WL_ENTER;
      WL_ENTER:   if (cnt_zero) state_d = WL_RUN;
      WL_RUN:     if (cnt_zero && pulse_q == '0) state_d = WL_EXIT;
      WL_EXIT:    if (cnt_zero) state_d = DONE;
`else
      ZQCL:       if (cnt_zero) state_d = DONE;
`endif
      DONE:       if (restart_i) state_d = RESET_HOLD;
      default:    state_d = RESET_HOLD;
    endcase
    entering = (state_d != state_q);

    // The first edge after reset release loads RESET_HOLD's wait.
    cnt_d = cnt_q;
    if (entering || !armed_q) cnt_d = CW'(wait_len(state_d) - 1);
`ifdef SDDR_WRITE_LEVEL_EN
    else if (state_q == WL_RUN && cnt_zero) cnt_d = CW'(WL_GAP - 1);
`endif
    else if (!cnt_zero) cnt_d = cnt_q - 1'b1;

    reset_n_d = (state_d != RESET_HOLD);
    cke_d     = (state_d != RESET_HOLD) && (state_d != CKE_WAIT);
    done_d    = (state_d == DONE);
    cmd_d     = cke_d ? CMD_NOP : CMD_DESEL;
    addr_d    = '0;
    ba_d      = '0;
    if (entering) begin
      case (state_d)
        MRS2: begin cmd_d = CMD_MRS; ba_d = BANK_BITS'(2); addr_d = MR2_VAL; end
        MRS3: begin cmd_d = CMD_MRS; ba_d = BANK_BITS'(3); addr_d = MR3_VAL; end
        MRS1: begin cmd_d = CMD_MRS; ba_d = BANK_BITS'(1); addr_d = MR1_VAL; end
        MRS0: begin cmd_d = CMD_MRS; ba_d = BANK_BITS'(0); addr_d = MR0_VAL; end
        ZQCL: begin cmd_d = CMD_ZQCL; addr_d[10] = 1'b1; end
`ifdef SDDR_WRITE_LEVEL_EN
        WL_ENTER: begin cmd_d = CMD_MRS; ba_d = BANK_BITS'(1); addr_d = MR1_VAL | (ADDR_BITS'(1) << 7); end
        WL_EXIT:  begin cmd_d = CMD_MRS; ba_d = BANK_BITS'(1); addr_d = MR1_VAL; end
`endif
        default: ;
      endcase
    end

`ifdef SDDR_WRITE_LEVEL_EN
    // Write-level mode and ODT turn on the cycle after the MR1 write that enables them.
    wl_d    = (state_d == WL_ENTER && !entering) || (state_d == WL_RUN);
    dqs_d   = (state_d == WL_RUN) && (entering || cnt_zero);
    pulse_d = pulse_q;
    if (entering && state_d == WL_RUN) pulse_d = PW'(WL_PULSES - 1);
    else if (state_q == WL_RUN && cnt_zero && pulse_q != '0) pulse_d = pulse_q - 1'b1;
`endif
  end

  always_ff @(posedge in_ddr_clock_i or negedge in_ctl_reset_n_i) begin
    if (!in_ctl_reset_n_i) begin
      state_q       <= RESET_HOLD;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      ddr_reset_n_o <= 1'b0;
      ctl_cke_o     <= 1'b0;
      cmd_q         <= CMD_DESEL;
      ctl_addr_o    <= '0;
      ctl_ba_o      <= '0;
      init_done_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      armed_q       <= 1'b1;
      ddr_reset_n_o <= reset_n_d;
      ctl_cke_o     <= cke_d;
      cmd_q         <= cmd_d;
      ctl_addr_o    <= addr_d;
      ctl_ba_o      <= ba_d;
      init_done_o   <= done_d;
    end
  end

`ifdef SDDR_WRITE_LEVEL_EN
  always_ff @(posedge in_ddr_clock_i or negedge in_ctl_reset_n_i) begin
    if (!in_ctl_reset_n_i) begin
      pulse_q <= '0;
      wl_q    <= 1'b0;
      dqs_q   <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      wl_q    <= wl_d;
      dqs_q   <= dqs_d;
    end
  end
  assign ctl_write_level_o = wl_q;
  assign ctl_odt_o         = wl_q;
  assign ctl_out_dqs_o     = dqs_q;
`else
  assign ctl_write_level_o = 1'b0;
  assign ctl_odt_o         = 1'b0;
  assign ctl_out_dqs_o     = 1'b0;
`endif

  assign {ctl_cs_n_o, ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} = cmd_q;
  assign state_o = state_q;

endmodule
